mem_access_ctrl: RTL

- Sequences one memory transaction through MAR, the memory data register and the RAM on behalf of the CPU control unit.
- Drives the MDR load enable and read-select, plus the RAM read/write strobes, with a programmable wait-state count and optional memory-ready handshake.
- Sits between the control-unit step decoder and the MAR/MDR/RAM datapath.
- Returns a one-cycle done pulse, or an error pulse on handshake timeout.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/mem_access_ctrl_if.sv | 27 ++
 rtl/mem_access_ctrl_wait_counter.sv | 37 +++
 rtl/mem_access_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory access controller: state encoding,
// read/write polarity and counter width.
package cpu_pkg;

    localparam int CNT_W = 4;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Control-unit request/response handshake plus the MAR/MDR/RAM strobes
// driven by the memory access controller.
interface mem_access_ctrl_if;

    logic start;
    logic rw;
    logic mem_ready;
    logic mar_in;
    logic mdr_in;
    logic mdr_read;
    logic mem_read;
    logic mem_write;
    logic busy;
    logic done;
    logic err;

    modport master (
        output start, rw, mem_ready,
        input  mar_in, mdr_in, mdr_read, mem_read, mem_write, busy, done, err
    );

    modport slave (
        input  start, rw, mem_ready,
        output mar_in, mdr_in, mdr_read, mem_read, mem_write, busy, done, err
    );

endinterface

// File: rtl/mem_access_ctrl_wait_counter.sv
// Wait-state down-counter (saturating, with zero flag) and a free-running
// up-counter used to bound the memory-ready handshake.
module mem_access_ctrl_wait_counter
    import cpu_pkg::*;
#(
    parameter int unsigned LOAD_VAL = 2
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             i_load,
    input  logic             i_run,
    output logic             o_wait_zero,
    output logic [CNT_W-1:0] o_tmo
);

    logic [CNT_W-1:0] r_wait;
    logic [CNT_W-1:0] r_tmo;

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_wait <= '0;
            r_tmo  <= '0;
        end else if (i_load) begin
            r_wait <= CNT_W'(LOAD_VAL);
            r_tmo  <= '0;
        end else if (i_run) begin
            if (r_wait != '0) begin
                r_wait <= r_wait - CNT_W'(1);
            end
            r_tmo <= r_tmo + CNT_W'(1);
        end
    end

    assign o_wait_zero = (r_wait == '0);
    assign o_tmo       = r_tmo;

endmodule

// File: rtl/mem_access_ctrl.sv
// Moore FSM sequencing one MAR -> RAM -> MDR transaction, with wait states
// and an optional bounded memory-ready handshake.
module mem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned USE_READY = 0,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic               clock,
    input  logic               clear,
    mem_access_ctrl_if.slave   bus
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_rw_q;
    logic             w_wait_zero;
    logic [CNT_W-1:0] w_tmo;
    logic             w_exit;
    logic             w_timeout;

    mem_access_ctrl_wait_counter #(
        .LOAD_VAL (LATENCY)
    ) u_wait_counter (
        .clock       (clock),
        .clear       (clear),
        .i_load      (r_state == ST_ADDR),
        .i_run       (r_state == ST_ACCESS),
        .o_wait_zero (w_wait_zero),
        .o_tmo       (w_tmo)
    );

    // Exit wins over timeout when both would fire in the same ACCESS cycle.
    assign w_exit    = w_wait_zero && ((USE_READY == 0) || bus.mem_ready);
    assign w_timeout = (USE_READY != 0) && (w_tmo == TMO_LAST);

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state <= ST_IDLE;
            r_rw_q  <= RW_WRITE;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && bus.start) begin
                r_rw_q <= bus.rw;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (bus.start) w_state_next = ST_ADDR;
            ST_ADDR:    w_state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (w_exit) begin
                    w_state_next = (r_rw_q == RW_READ) ? ST_CAPTURE : ST_DONE;
                end else if (w_timeout) begin
                    w_state_next = ST_ERR;
                end
            end
            ST_CAPTURE: w_state_next = ST_DONE;
            ST_DONE:    w_state_next = ST_IDLE;
            ST_ERR:     w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.mar_in    = 1'b0;
        bus.mdr_in    = 1'b0;
        bus.mdr_read  = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        unique case (r_state)
            ST_ADDR: begin
                bus.mar_in = 1'b1;
                bus.busy   = 1'b1;
            end
            ST_ACCESS: begin
                bus.busy      = 1'b1;
                bus.mem_read  = r_rw_q;
                bus.mem_write = ~r_rw_q;
            end
            ST_CAPTURE: begin
                bus.mdr_in   = 1'b1;
                bus.mdr_read = 1'b1;
                bus.mem_read = 1'b1;
                bus.busy     = 1'b1;
            end
            ST_DONE: bus.done = 1'b1;
            ST_ERR: begin
                bus.done = 1'b1;
                bus.err  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
